// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: jump opcodes, the
// bubble word, the fetch FSM encoding and the IF/ID register layout.
package instr_fetch_stage_pkg;

  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [5:0]  OP_JAL    = 6'b000011;
  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // 65-bit IF/ID payload.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_ifid_reg.sv
// IF/ID pipeline register {instr, pc_plus4, valid}.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active-low (loads a bubble)
//   hold_i   keep the current contents
//   flush_i  load a bubble; wins over hold_i
//   d_i      next contents when neither hold nor flush
//   q_o      current contents
module ifid_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  localparam ifid_t BUBBLE = '{instr: FLUSH_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  ifid_t r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_q <= BUBBLE;
    end else if (flush_i) begin
      r_q <= BUBBLE;
    end else if (!hold_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, next-PC selection (sequential, EX branch, ID jr,
// ID j/jal), stall/flush handling and the IF/ID register feeding decode.
// Ports:
//   clk_i, rst_i               clock / async active-low reset
//   imem_addr_o, imem_data_i   combinational instruction memory read
//   stall_i                    hold PC and IF/ID
//   branch_taken_i/_target_i   EX-stage branch redirect
//   jr_i, jr_target_i          ID-stage jr redirect
//   instr_o, pc_plus4_o,
//   valid_o                    IF/ID contents
//   jump_o                     j/jal in IF/ID is redirecting this cycle
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instr_fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        jump_o
);

  fetch_state_e r_state, w_next_state;
  logic [31:0]  r_pc, w_next_pc, w_sel_pc, w_pc_plus4, w_jump_target;
  logic         w_hold, w_flush, w_jump, w_is_jump;
  ifid_t        w_ifid_d, w_ifid_q;

  assign w_pc_plus4    = r_pc + 32'd4;  // wraps modulo 2^32
  assign w_jump_target = {w_ifid_q.pc_plus4[31:28], w_ifid_q.instr[25:0], 2'b00};
  assign w_is_jump     = w_ifid_q.valid && is_jump_op(w_ifid_q.instr[31:26]);

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_sel_pc     = r_pc;
    w_hold       = 1'b0;
    w_flush      = 1'b0;
    w_jump       = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_flush      = 1'b1;
      end
      RUN: begin
        // A taken branch overrides a stall: the stalled ID instruction is on
        // the wrong path anyway.
        if (branch_taken_i) begin
          w_sel_pc = branch_target_i;
          w_flush  = 1'b1;
        end else if (stall_i) begin
          w_hold   = 1'b1;
        end else if (jr_i) begin
          w_sel_pc = jr_target_i;
          w_flush  = 1'b1;
        end else if (w_is_jump) begin
          w_sel_pc = w_jump_target;
          w_flush  = 1'b1;
          w_jump   = 1'b1;
        end else begin
          w_sel_pc = w_pc_plus4;
        end
      end
      default: w_next_state = BOOT;
    endcase
  end

  // Misaligned redirect targets are truncated to a word boundary.
  assign w_next_pc = {w_sel_pc[31:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= BOOT;
      r_pc    <= {RESET_PC[31:2], 2'b00};
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  assign w_ifid_d = '{instr: imem_data_i, pc_plus4: w_pc_plus4, valid: 1'b1};

  ifid_reg #(
    .FLUSH_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (w_hold),
    .flush_i (w_flush),
    .d_i     (w_ifid_d),
    .q_o     (w_ifid_q)
  );

  assign imem_addr_o = r_pc;
  assign instr_o     = w_ifid_q.instr;
  assign pc_plus4_o  = w_ifid_q.pc_plus4;
  assign valid_o     = w_ifid_q.valid;
  assign jump_o      = w_jump;

endmodule
